// File: rtl/arb_pkg.sv
// Shared types for the memory-bus arbiter: FSM states, owner tags and
// arbitration-policy selectors.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  localparam int ARB_FIXED_LSU   = 0;
  localparam int ARB_ROUND_ROBIN = 1;
endpackage

// File: rtl/arb_watchdog.sv
// Saturating cycle counter with clear/enable; expired holds while the count
// sits at LIMIT. LIMIT = 0 disables it (expired tied low).
module arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  generate
    if (LIMIT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [W-1:0] MAX = W'(LIMIT);
      logic [W-1:0] cnt;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset)                    cnt <= '0;
        else if (clear)                cnt <= '0;
        else if (enable && cnt != MAX) cnt <= cnt + W'(1);
      end

      assign expired = (cnt == MAX);
    end
  endgenerate
endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single memory bus port, one outstanding
// transaction, with a watchdog that turns a hung bus into an error response.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_reqReady,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_reqValid,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_reqReady,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);
  state_e state;
  owner_e owner, last_grant;
  logic   grant_ifu, grant_lsu;
  logic   expired, timeout, resp_fire, done;

  // Grant depends only on requests and registered state; reset gating keeps
  // reqReady low while reset is held even though state already reads IDLE.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && reset) begin
      if (ifu_reqValid && lsu_reqValid) begin
        if (ARB_MODE == ARB_ROUND_ROBIN && last_grant == OWN_LSU) grant_ifu = 1'b1;
        else                                                      grant_lsu = 1'b1;
      end else begin
        grant_ifu = ifu_reqValid;
        grant_lsu = lsu_reqValid;
      end
    end
  end

  arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .expired (expired)
  );

  // A handshake landing on the expiry cycle wins over the timeout.
  assign timeout   = expired && ((state == REQ && !mem_reqReady) ||
                                 (state == RESP && !mem_respValid));
  assign resp_fire = (state == RESP) && mem_respValid;
  assign done      = resp_fire || timeout;

  assign ifu_reqReady  = grant_ifu;
  assign lsu_reqReady  = grant_lsu;
  assign mem_reqValid  = (state == REQ);

  assign ifu_respValid = done && owner == OWN_IFU;
  assign ifu_rdata     = (resp_fire && owner == OWN_IFU) ? mem_rdata : '0;
  assign ifu_err       = ifu_respValid && (timeout || mem_err);
  assign lsu_respValid = done && owner == OWN_LSU;
  assign lsu_rdata     = (resp_fire && owner == OWN_LSU) ? mem_rdata : '0;
  assign lsu_err       = lsu_respValid && (timeout || mem_err);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        IDLE: if (grant_ifu || grant_lsu) begin
          owner      <= grant_lsu ? OWN_LSU : OWN_IFU;
          last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
          mem_wen    <= grant_lsu && lsu_wen;
          mem_addr   <= grant_lsu ? lsu_addr : ifu_addr;
          mem_wdata  <= grant_lsu ? lsu_wdata : '0;
          mem_wmask  <= grant_lsu ? lsu_wmask : '0;
          state      <= REQ;
        end
        REQ: begin
          if (mem_reqReady) state <= RESP;
          else if (timeout) state <= IDLE;
        end
        RESP: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
